// File: rtl/router_3of6_pkg.sv
// Shared constants and types for the 3-of-6 receive path (assembler and decoder).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package router_3of6_pkg;

  localparam int SYM_W   = 6;
  localparam int SYMBOLS = 8;
  localparam int FLIT_W  = SYM_W * SYMBOLS;
  localparam int CNT_W   = 3;

  // All-zero symbol is never a legal 3-of-6 codeword, so the link uses it as idle fill.
  localparam logic [SYM_W-1:0] SPACER = '0;

  typedef logic [SYM_W-1:0]  sym_t;
  typedef logic [FLIT_W-1:0] flit_t;

  // Assembly state is implied by the symbol index: zero means no partial flit held.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } asm_state_e;

endpackage

// File: rtl/flit_assembler_3of6.sv
// Packs 8 non-spacer 3-of-6 symbols into a 48-bit flit; realigns on sof, counts misaligns.
// Latency: flit_valid rises 1 cycle after the 8th symbol is accepted.
// Backpressure: one-deep output buffer; only the completing symbol stalls, and only while the buffer is full and not draining.
module flit_assembler_3of6
  import router_3of6_pkg::*;
#(
  parameter int ERRCNT_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sym_valid,
  input  logic [SYM_W-1:0]    sym_data,
  input  logic                sym_sof,
  output logic                sym_ready,
  output logic                flit_valid,
  output logic [FLIT_W-1:0]   flit_data,
  input  logic                flit_ready,
  output logic                align_err,
  output logic [ERRCNT_W-1:0] align_err_cnt
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(SYMBOLS - 1);

  // The 8th symbol never lands in the assembly reg; it goes straight into the output word.
  logic [CNT_W-1:0]                  cnt_q,     cnt_d;
  logic [SYMBOLS-2:0][SYM_W-1:0]     slots_q,   slots_d;
  logic [FLIT_W-1:0]                 flit_q,    flit_d;
  logic                              flit_vld_q, flit_vld_d;
  logic                              err_q,     err_d;
  logic [ERRCNT_W-1:0]               err_cnt_q, err_cnt_d;

  logic       is_spacer;
  logic       accept;
  asm_state_e state;

  assign is_spacer = ~|sym_data;
  assign state     = (cnt_q == '0) ? ST_IDLE : ST_FILL;

  // Only the completing symbol needs buffer space; earlier symbols always have room.
  assign sym_ready = (cnt_q != LAST) | ~flit_vld_q | flit_ready;
  assign accept    = sym_valid & sym_ready & ~is_spacer;

  // Next-state: slot write, realign on sof, hand-off of the full word to the output buffer.
  always_comb begin
    cnt_d      = cnt_q;
    slots_d    = slots_q;
    flit_d     = flit_q;
    flit_vld_d = flit_vld_q;
    err_d      = 1'b0;
    err_cnt_d  = err_cnt_q;

    if (flit_vld_q && flit_ready) begin
      flit_vld_d = 1'b0;
    end

    if (accept) begin
      if (state == ST_IDLE || sym_sof) begin
        slots_d[0] = sym_data;
        cnt_d      = CNT_W'(1);
        if (state == ST_FILL) begin
          err_d = 1'b1;
          if (err_cnt_q != '1) begin
            err_cnt_d = err_cnt_q + ERRCNT_W'(1);
          end
        end
      end else if (cnt_q == LAST) begin
        // A load in the same cycle as a consume overrides the clear above: no bubble.
        flit_d     = {sym_data, slots_q};
        flit_vld_d = 1'b1;
        cnt_d      = '0;
      end else begin
        for (int i = 1; i < SYMBOLS - 1; i++) begin
          if (cnt_q == CNT_W'(i)) begin
            slots_d[i] = sym_data;
          end
        end
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // State registers; reset drops any partial or buffered flit silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      slots_q    <= '0;
      flit_q     <= '0;
      flit_vld_q <= 1'b0;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      cnt_q      <= cnt_d;
      slots_q    <= slots_d;
      flit_q     <= flit_d;
      flit_vld_q <= flit_vld_d;
      err_q      <= err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign flit_valid    = flit_vld_q;
  assign flit_data     = flit_q;
  assign align_err     = err_q;
  assign align_err_cnt = err_cnt_q;

endmodule

// File: tb/tb_flit_assembler_3of6.sv
// Directed bench for flit_assembler_3of6.
// Latency: n/a.
// Backpressure: flit_ready driven per scenario.
module tb_flit_assembler_3of6;

  logic        clk;
  logic        rst_n;
  logic        sym_valid;
  logic [5:0]  sym_data;
  logic        sym_sof;
  logic        sym_ready;
  logic        flit_valid;
  logic [47:0] flit_data;
  logic        flit_ready;
  logic        align_err;
  logic [7:0]  align_err_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  int          hs_cnt     = 0;
  logic [47:0] last_hs    = '0;
  int          err_pulses = 0;

  logic [5:0] s1 [8] = '{6'h07, 6'h0E, 6'h15, 6'h38, 6'h23, 6'h2A, 6'h31, 6'h0B};
  logic [5:0] sb [8] = '{6'h19, 6'h1A, 6'h1C, 6'h25, 6'h26, 6'h29, 6'h2C, 6'h32};

  // Hand-packed: last-received symbol at the top, first-received at [5:0].
  logic [47:0] e1 = {6'h0B, 6'h31, 6'h2A, 6'h23, 6'h38, 6'h15, 6'h0E, 6'h07};
  logic [47:0] eb = {6'h32, 6'h2C, 6'h29, 6'h26, 6'h25, 6'h1C, 6'h1A, 6'h19};

  flit_assembler_3of6 #(.ERRCNT_W(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sym_valid     (sym_valid),
    .sym_data      (sym_data),
    .sym_sof       (sym_sof),
    .sym_ready     (sym_ready),
    .flit_valid    (flit_valid),
    .flit_data     (flit_data),
    .flit_ready    (flit_ready),
    .align_err     (align_err),
    .align_err_cnt (align_err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (flit_valid && flit_ready) begin
      hs_cnt  <= hs_cnt + 1;
      last_hs <= flit_data;
    end
    if (align_err) err_pulses <= err_pulses + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Present one symbol from the falling edge until it is taken; returns #1 after the accepting edge.
  task automatic send_sym(input logic [5:0] d, input logic s);
    int waited;
    waited = 0;
    @(negedge clk);
    sym_valid = 1'b1;
    sym_data  = d;
    sym_sof   = s;
    while (!sym_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!sym_ready) begin
      n_cmp++; n_fail++;
      $display("FAIL send_timeout: sym_ready=%b after %0d cycles, required 1", sym_ready, waited);
    end
    @(posedge clk);
    #1;
    sym_valid = 1'b0;
    sym_sof   = 1'b0;
    sym_data  = 6'h00;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sym_valid = 1'b0; sym_data = 6'h00; sym_sof = 1'b0; flit_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (flit_valid !== 1'b0) begin n_fail++; $display("FAIL rst_flit_valid: got %b want 0", flit_valid); end
    n_cmp++; if (flit_data !== 48'h0) begin n_fail++; $display("FAIL rst_flit_data: got %h want 0", flit_data); end
    n_cmp++; if (align_err !== 1'b0) begin n_fail++; $display("FAIL rst_align_err: got %b want 0", align_err); end
    n_cmp++; if (align_err_cnt !== 8'h00) begin n_fail++; $display("FAIL rst_err_cnt: got %h want 00", align_err_cnt); end
    n_cmp++; if (sym_ready !== 1'b1) begin n_fail++; $display("FAIL rst_sym_ready: got %b want 1", sym_ready); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    flit_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send_sym(s1[i], i == 0);
      if (i == 6) begin
        n_cmp++; if (flit_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid: got %b want 0", flit_valid); end
      end
    end
    n_cmp++; if (flit_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b want 1", flit_valid); end
    n_cmp++; if (flit_data !== e1) begin n_fail++; $display("FAIL basic_data: got %h want %h", flit_data, e1); end
    @(posedge clk); #1;
    n_cmp++; if (flit_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_drop: got %b want 0", flit_valid); end
  endtask

  task automatic test_backpressure();
    int hs0;
    hs0 = hs_cnt;
    flit_ready = 1'b0;
    for (int i = 0; i < 8; i++) send_sym(s1[i], i == 0);
    n_cmp++; if (flit_data !== e1) begin n_fail++; $display("FAIL bp_first: got %h want %h", flit_data, e1); end
    for (int i = 0; i < 7; i++) send_sym(sb[i], i == 0);
    n_cmp++; if (flit_valid !== 1'b1 || flit_data !== e1) begin n_fail++; $display("FAIL bp_hold: got v=%b %h want v=1 %h", flit_valid, flit_data, e1); end
    @(negedge clk);
    sym_valid = 1'b1; sym_data = sb[7]; sym_sof = 1'b0;
    #1;
    n_cmp++; if (sym_ready !== 1'b0) begin n_fail++; $display("FAIL bp_stall: got %b want 0", sym_ready); end
    @(posedge clk); @(negedge clk);
    n_cmp++; if (sym_ready !== 1'b0 || flit_data !== e1) begin n_fail++; $display("FAIL bp_stall_hold: got rdy=%b %h want rdy=0 %h", sym_ready, flit_data, e1); end
    flit_ready = 1'b1;
    #1;
    n_cmp++; if (sym_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_rdy: got %b want 1", sym_ready); end
    @(posedge clk); #1;
    sym_valid = 1'b0; sym_data = 6'h00;
    n_cmp++; if (flit_valid !== 1'b1 || flit_data !== eb) begin n_fail++; $display("FAIL bp_no_gap: got v=%b %h want v=1 %h", flit_valid, flit_data, eb); end
    n_cmp++; if (hs_cnt - hs0 !== 1) begin n_fail++; $display("FAIL bp_first_consumed: got %0d want 1", hs_cnt - hs0); end
    @(posedge clk); #1;
    n_cmp++; if (flit_valid !== 1'b0 || hs_cnt - hs0 !== 2 || last_hs !== eb) begin n_fail++; $display("FAIL bp_second_consumed: got v=%b n=%0d %h want v=0 n=2 %h", flit_valid, hs_cnt - hs0, last_hs, eb); end
  endtask

  task automatic test_spacers();
    int ep0;
    ep0 = err_pulses;
    flit_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send_sym(s1[i], i == 0);
      if (i < 7) send_sym(6'h00, i == 3);
    end
    n_cmp++; if (flit_valid !== 1'b1 || flit_data !== e1) begin n_fail++; $display("FAIL spacer_data: got v=%b %h want v=1 %h", flit_valid, flit_data, e1); end
    @(posedge clk); #1;
    n_cmp++; if (err_pulses - ep0 !== 0 || align_err_cnt !== 8'h00) begin n_fail++; $display("FAIL spacer_no_err: got pulses=%0d cnt=%h want 0 00", err_pulses - ep0, align_err_cnt); end
  endtask

  task automatic test_misalign();
    int ep0;
    ep0 = err_pulses;
    flit_ready = 1'b1;
    send_sym(6'h0E, 1'b1);
    send_sym(6'h15, 1'b0);
    send_sym(6'h38, 1'b0);
    send_sym(6'h07, 1'b1);
    n_cmp++; if (align_err !== 1'b1) begin n_fail++; $display("FAIL misalign_pulse: got %b want 1", align_err); end
    n_cmp++; if (align_err_cnt !== 8'd1) begin n_fail++; $display("FAIL misalign_cnt: got %0d want 1", align_err_cnt); end
    for (int i = 1; i < 8; i++) send_sym(s1[i], 1'b0);
    n_cmp++; if (flit_valid !== 1'b1 || flit_data !== e1) begin n_fail++; $display("FAIL misalign_flit: got v=%b %h want v=1 %h", flit_valid, flit_data, e1); end
    n_cmp++; if (err_pulses - ep0 !== 1 || align_err !== 1'b0) begin n_fail++; $display("FAIL misalign_one_pulse: got %0d now=%b want 1 now=0", err_pulses - ep0, align_err); end
    @(posedge clk); #1;
  endtask

  task automatic test_saturate();
    send_sym(6'h07, 1'b1);
    for (int i = 0; i < 100; i++) send_sym(6'h07, 1'b1);
    n_cmp++; if (align_err_cnt !== 8'd101) begin n_fail++; $display("FAIL sat_mid: got %0d want 101", align_err_cnt); end
    for (int i = 0; i < 200; i++) send_sym(6'h07, 1'b1);
    n_cmp++; if (align_err_cnt !== 8'hFF) begin n_fail++; $display("FAIL sat_top: got %h want ff", align_err_cnt); end
    send_sym(6'h07, 1'b1);
    n_cmp++; if (align_err !== 1'b1 || align_err_cnt !== 8'hFF) begin n_fail++; $display("FAIL sat_hold: got err=%b cnt=%h want 1 ff", align_err, align_err_cnt); end
  endtask

  task automatic test_midflit_reset();
    int hs0;
    flit_ready = 1'b0;
    for (int i = 1; i < 8; i++) send_sym(s1[i], 1'b0);
    for (int i = 0; i < 5; i++) send_sym(sb[i], i == 0);
    n_cmp++; if (flit_valid !== 1'b1 || flit_data !== e1) begin n_fail++; $display("FAIL rst2_buffered: got v=%b %h want v=1 %h", flit_valid, flit_data, e1); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (flit_valid !== 1'b0 || flit_data !== 48'h0 || align_err !== 1'b0 || align_err_cnt !== 8'h00) begin
      n_fail++; $display("FAIL rst2_outputs: got v=%b d=%h e=%b c=%h want all 0", flit_valid, flit_data, align_err, align_err_cnt);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    flit_ready = 1'b1;
    hs0 = hs_cnt;
    for (int i = 0; i < 8; i++) send_sym(sb[i], i == 0);
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (hs_cnt - hs0 !== 1 || last_hs !== eb) begin n_fail++; $display("FAIL rst2_fresh: got n=%0d %h want n=1 %h", hs_cnt - hs0, last_hs, eb); end
    n_cmp++; if (align_err_cnt !== 8'h00) begin n_fail++; $display("FAIL rst2_err_cnt: got %h want 00", align_err_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_spacers();
    test_misalign();
    test_saturate();
    test_midflit_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
